// File: rtl/cam_pkg.sv
// Shared defaults and request record for the parameterised CAM.
package cam_pkg;

    localparam int CAM_DATA_WIDTH = 32;
    localparam int CAM_DEPTH      = 32;
    localparam int CAM_IDX_W      = $clog2(CAM_DEPTH);

    // One request on any CAM port: enable, target index and payload.
    typedef struct packed {
        logic                      enable;
        logic [CAM_IDX_W-1:0]      index;
        logic [CAM_DATA_WIDTH-1:0] data;
    } cam_op_t;

endpackage

// File: rtl/cam_if.sv
// Signal bundle for the CAM, with a design-side and a driver-side view.
interface cam_if import cam_pkg::*; #(
    parameter int  DATA_WIDTH = CAM_DATA_WIDTH,
    parameter int  DEPTH      = CAM_DEPTH,
    localparam int IDX_W      = $clog2(DEPTH)
) (
    input logic clk_i
);
    logic                  rst_i;
    logic                  read_enable_i;
    logic [IDX_W-1:0]      read_index_i;
    logic                  write_enable_i;
    logic [IDX_W-1:0]      write_index_i;
    logic [DATA_WIDTH-1:0] write_data_i;
    logic                  invalidate_enable_i;
    logic [IDX_W-1:0]      invalidate_index_i;
    logic                  search_enable_i;
    logic [DATA_WIDTH-1:0] search_data_i;
    logic [DATA_WIDTH-1:0] search_mask_i;
    logic                  read_valid_o;
    logic [DATA_WIDTH-1:0] read_value_o;
    logic                  search_valid_o;
    logic [IDX_W-1:0]      search_index_o;
    logic                  search_multi_o;
    logic [IDX_W:0]        entry_count_o;
    logic                  full_o;

    modport dut (
        input  clk_i, rst_i, read_enable_i, read_index_i,
               write_enable_i, write_index_i, write_data_i,
               invalidate_enable_i, invalidate_index_i,
               search_enable_i, search_data_i, search_mask_i,
        output read_valid_o, read_value_o, search_valid_o, search_index_o,
               search_multi_o, entry_count_o, full_o
    );

    modport bench (
        input  clk_i, read_valid_o, read_value_o, search_valid_o, search_index_o,
               search_multi_o, entry_count_o, full_o,
        output rst_i, read_enable_i, read_index_i,
               write_enable_i, write_index_i, write_data_i,
               invalidate_enable_i, invalidate_index_i,
               search_enable_i, search_data_i, search_mask_i
    );

endinterface

// File: rtl/cam_prio_enc.sv
// Match vector to hit flag, lowest matching index and multiple-hit flag.
module cam_prio_enc #(
    parameter int  DEPTH = 32,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] match,
    output logic             hit,
    output logic [IDX_W-1:0] index,
    output logic             multi
);

    // Scan upward; the first set bit gives the index, any later one flags multi.
    always_comb begin
        hit   = 1'b0;
        index = '0;
        multi = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (match[i]) begin
                if (hit) begin
                    multi = 1'b1;
                end else begin
                    hit   = 1'b1;
                    index = i[IDX_W-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/param_cam.sv
// Parameterised CAM with masked search, per-entry valid bits and occupancy count.
module param_cam import cam_pkg::*; #(
    parameter int  DATA_WIDTH = CAM_DATA_WIDTH,
    parameter int  DEPTH      = CAM_DEPTH,
    localparam int IDX_W      = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  read_enable_i,
    input  logic [IDX_W-1:0]      read_index_i,
    input  logic                  write_enable_i,
    input  logic [IDX_W-1:0]      write_index_i,
    input  logic [DATA_WIDTH-1:0] write_data_i,
    input  logic                  invalidate_enable_i,
    input  logic [IDX_W-1:0]      invalidate_index_i,
    input  logic                  search_enable_i,
    input  logic [DATA_WIDTH-1:0] search_data_i,
    input  logic [DATA_WIDTH-1:0] search_mask_i,
    output logic                  read_valid_o,
    output logic [DATA_WIDTH-1:0] read_value_o,
    output logic                  search_valid_o,
    output logic [IDX_W-1:0]      search_index_o,
    output logic                  search_multi_o,
    output logic [IDX_W:0]        entry_count_o,
    output logic                  full_o
);

    localparam logic [IDX_W:0] DEPTH_C = DEPTH[IDX_W:0];

    // Indices past the last entry are legal encodings but address nothing.
    function automatic logic idx_ok(input logic [IDX_W-1:0] idx);
        return ({1'b0, idx} < DEPTH_C);
    endfunction

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0]      entry_vld;
    logic [DEPTH-1:0]      match;
    logic                  wr_ok, inv_ok, cnt_inc, cnt_dec, rd_hit;
    logic                  enc_hit, enc_multi;
    logic [IDX_W-1:0]      enc_idx;
    logic [IDX_W:0]        count_nxt;

    logic                  rd_vld_p1;
    logic [DATA_WIDTH-1:0] rd_val_p1;
    logic                  sr_vld_p1;
    logic [IDX_W-1:0]      sr_idx_p1;
    logic                  sr_multi_p1;
    logic [IDX_W:0]        count_p1;
    logic                  full_p1;

    // Request qualification and occupancy delta; a write to the same index overrides invalidate.
    always_comb begin
        wr_ok     = write_enable_i && idx_ok(write_index_i);
        inv_ok    = invalidate_enable_i && idx_ok(invalidate_index_i)
                    && !(wr_ok && (write_index_i == invalidate_index_i));
        cnt_inc   = wr_ok && !entry_vld[write_index_i];
        cnt_dec   = inv_ok && entry_vld[invalidate_index_i];
        count_nxt = count_p1 + {{IDX_W{1'b0}}, cnt_inc} - {{IDX_W{1'b0}}, cnt_dec};
        rd_hit    = read_enable_i && idx_ok(read_index_i) && entry_vld[read_index_i];
    end

    // Per-entry masked compare against the pre-edge contents.
    always_comb begin
        match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match[i] = entry_vld[i] && (((mem[i] ^ search_data_i) & search_mask_i) == '0);
        end
    end

    cam_prio_enc #(
        .DEPTH (DEPTH)
    ) u_prio_enc (
        .match (match),
        .hit   (enc_hit),
        .index (enc_idx),
        .multi (enc_multi)
    );

    // Entry data storage; contents survive reset and invalidation.
    always_ff @(posedge clk_i) begin
        if (wr_ok) begin
            mem[write_index_i] <= write_data_i;
        end
    end

    // Valid bits: invalidate clears, write sets (write applied last so it wins).
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            entry_vld <= '0;
        end else begin
            if (inv_ok) entry_vld[invalidate_index_i] <= 1'b0;
            if (wr_ok)  entry_vld[write_index_i]      <= 1'b1;
        end
    end

    // Registered results: one-cycle read/search pulses, count and full flag.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rd_vld_p1   <= 1'b0;
            rd_val_p1   <= '0;
            sr_vld_p1   <= 1'b0;
            sr_idx_p1   <= '0;
            sr_multi_p1 <= 1'b0;
            count_p1    <= '0;
            full_p1     <= 1'b0;
        end else begin
            rd_vld_p1   <= rd_hit;
            rd_val_p1   <= rd_hit ? mem[read_index_i] : '0;
            sr_vld_p1   <= search_enable_i && enc_hit;
            sr_idx_p1   <= (search_enable_i && enc_hit) ? enc_idx : '0;
            sr_multi_p1 <= search_enable_i && enc_multi;
            count_p1    <= count_nxt;
            full_p1     <= (count_nxt == DEPTH_C);
        end
    end

    assign read_valid_o   = rd_vld_p1;
    assign read_value_o   = rd_val_p1;
    assign search_valid_o = sr_vld_p1;
    assign search_index_o = sr_idx_p1;
    assign search_multi_o = sr_multi_p1;
    assign entry_count_o  = count_p1;
    assign full_o         = full_p1;

endmodule

// File: doc/param_cam.md
PARAM_CAM -- requirements
Module: param_cam

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, entry and search-key width in bits.
REQ-002 Parameter: DEPTH, default 32, number of entries (2..256, not necessarily a power of two).
REQ-003 Parameter: IDX_W, default $clog2(DEPTH), index width (derived, not overridden).
REQ-004 clk_i  in  1  sole clock, all state on rising edge.
REQ-005 rst_i  in  1  reset, asynchronous, active-low.
REQ-006 read_enable_i  in  1  read request; read_index_i  in  IDX_W  read address.
REQ-007 write_enable_i  in  1  write request; write_index_i  in  IDX_W; write_data_i  in  DATA_WIDTH.
REQ-008 invalidate_enable_i  in  1  clear entry valid bit; invalidate_index_i  in  IDX_W.
REQ-009 search_enable_i  in  1  search request; search_data_i  in  DATA_WIDTH key; search_mask_i  in  DATA_WIDTH, bit=1 means compare, 0 means don't-care.
REQ-010 read_valid_o  out  1; read_value_o  out  DATA_WIDTH.
REQ-011 search_valid_o  out  1 hit; search_index_o  out  IDX_W lowest matching index; search_multi_o  out  1 more than one hit.
REQ-012 entry_count_o  out  IDX_W+1  number of valid entries; full_o  out  1  entry_count_o==DEPTH.

Function
REQ-013 Storage: DEPTH entries of DATA_WIDTH data plus one valid bit each.
REQ-014 All outputs registered; read and search results appear exactly 1 cycle after the request cycle.
REQ-015 Read: read_valid_o=1 and read_value_o=entry data iff the addressed entry is valid; otherwise read_valid_o=0, read_value_o=0.
REQ-016 Read/search outputs are single-cycle: with no request, valid flags=0 and data/index outputs=0.
REQ-017 Write: stores data and sets valid; entry_count_o increments only if the entry was previously invalid.
REQ-018 Invalidate: clears valid; entry_count_o decrements only if the entry was previously valid; data is not cleared.
REQ-019 Search match per entry: valid AND ((entry ^ search_data_i) & search_mask_i)==0; an all-zero mask matches every valid entry.
REQ-020 search_valid_o=1 if any entry matches; search_index_o=lowest matching index; search_multi_o=1 if two or more match; all 0 on miss.
REQ-021 Read and search sample pre-edge contents: a same-cycle write/invalidate is not visible until the following cycle.
REQ-022 Write and invalidate to the same index in one cycle: write wins, entry valid, count adjusted per REQ-017 only.
REQ-023 Write and invalidate to different indices in one cycle: both take effect; net count change computed from both.
REQ-024 Index >= DEPTH: write/invalidate ignored, read returns read_valid_o=0.
REQ-025 Writes proceed when full_o=1 (overwrite); count saturates at DEPTH by construction.
REQ-026 Read, write, invalidate and search are independent and may all be asserted in the same cycle.

Reset
REQ-027 rst_i low asynchronously clears all valid bits, entry_count_o, full_o and every output flag/value to 0.
REQ-028 Entry data is not reset; an operation in flight at reset assertion produces no result.
REQ-029 First operation is accepted on the first rising edge after rst_i deasserts.

Structure
REQ-030 Package cam_pkg holds default DATA_WIDTH/DEPTH constants and the cam_op_t request struct (enable, index, data) shared with the bench.
REQ-031 One sub-module cam_prio_enc: DEPTH-bit match vector -> hit, lowest index, multi flag (combinational).
REQ-032 Existing cam interface is extended with invalidate, mask, count and full signals; modports dut and bench kept.

Verification
REQ-033 Reset, write 0xDEADBEEF to idx 5, read idx 5 next cycle -> read_valid_o=1, read_value_o=0xDEADBEEF, entry_count_o=1.
REQ-034 Write 0x1234 to idx 3 and 9, search 0x1234 mask all-ones -> search_valid_o=1, search_index_o=3, search_multi_o=1.
REQ-035 Write 0xAB00 idx 2, search 0xABFF mask 0xFF00 -> hit idx 2; same with mask 0xFFFF -> search_valid_o=0.
REQ-036 Write and invalidate idx 7 same cycle -> idx 7 valid, count +1; then invalidate idx 7 -> read returns read_valid_o=0, count -1.
REQ-037 Fill all DEPTH entries -> full_o=1, entry_count_o=DEPTH; overwrite idx 0 -> count unchanged; assert rst_i mid-stream -> all outputs 0, search misses.
REQ-038 Write idx 4 and search its new value same cycle -> miss; repeat search next cycle -> hit idx 4.
